// File: rtl/score_ctrl.sv
// Game-phase sequencer and BCD score accumulator with a digit-serial adder.
// Optional high-score register enabled by defining SCORE_HISCORE_EN.
module score_ctrl #(
  parameter logic [15:0] CP1   = 16'd648,
  parameter logic [15:0] CP2   = 16'd1298,
  parameter logic [1:0]  LIVES = 2'd3
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        start_btn,
  input  logic        alive,
  input  logic        enemy1_alive,
  input  logic        save_suc,
  input  logic        lastp_alive,
  input  logic        p2_alive,
  input  logic [15:0] bg_position,
  output logic        game_start,
  output logic [2:0]  state,
  output logic [1:0]  lives,
  output logic [15:0] score,
`ifdef SCORE_HISCORE_EN
  output logic [15:0] hi_score,
`endif
  output logic        busy
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_START   = 3'd1;
  localparam logic [2:0] S_PLAY    = 3'd2;
  localparam logic [2:0] S_RESPAWN = 3'd3;
  localparam logic [2:0] S_OVER    = 3'd4;
  localparam logic [2:0] S_WIN     = 3'd5;

  // Input bit order: start, alive, enemy1_alive, save_suc, lastp_alive, p2_alive.
  // The *_alive bits reset high so release from reset never looks like a kill.
  localparam logic [5:0] IN_RST = 6'b011011;

  function automatic logic [4:0] bcd_digit_add(input logic [3:0] a, input logic [3:0] b,
                                               input logic cin);
    logic [4:0] s;
    s = {1'b0, a} + {1'b0, b} + {4'd0, cin};
    if (s > 5'd9) s = s + 5'd6;
    return s;
  endfunction

  function automatic logic [15:0] bcd_saturate(input logic [15:0] v, input logic ovf);
    return ovf ? 16'h9999 : v;
  endfunction

  function automatic logic [15:0] award_value(input logic [4:0] sel);
    case (sel)
      5'b00001:          return 16'h0020;
      5'b00010:          return 16'h0030;
      5'b00100, 5'b01000: return 16'h0050;
      5'b10000:          return 16'h0100;
      default:           return 16'h0000;
    endcase
  endfunction

  logic [5:0]  in_q, prev_q, rise_q, fall_q;
  logic [15:0] bg1_q, bg2_q;
  logic [2:0]  state_q, state_d;
  logic [1:0]  lives_q, lives_d;
  logic [4:0]  pend_q, pend_d, new_p, sel;
  logic        a_busy_q, a_busy_d, carry_q, carry_d, win_entry, play;
  logic [1:0]  dig_q, dig_d;
  logic [15:0] addend_q, addend_d, score_q, score_d;
  logic [4:0]  dsum;

  always_comb begin
    state_d   = state_q;
    lives_d   = lives_q;
    win_entry = 1'b0;
    case (state_q)
      S_IDLE:  if (rise_q[5]) state_d = S_START;
      S_START: begin
        state_d = S_PLAY;
        lives_d = LIVES;
      end
      S_PLAY: begin
        if (fall_q[4]) begin
          lives_d = lives_q - 2'd1;
          state_d = (lives_q <= 2'd1) ? S_OVER : S_RESPAWN;
        end else if ((bg2_q > CP2) && !prev_q[1] && !prev_q[0]) begin
          state_d   = S_WIN;
          win_entry = 1'b1;
        end
      end
      S_RESPAWN: if (rise_q[4]) state_d = S_PLAY;
      S_OVER, S_WIN: if (rise_q[5]) state_d = S_START;
      default: state_d = S_IDLE;
    endcase
  end

  assign play     = (state_q == S_PLAY);
  assign new_p[0] = play && fall_q[3] && (bg2_q > CP1);
  assign new_p[1] = play && rise_q[2] && (bg2_q > CP1);
  assign new_p[2] = play && fall_q[1] && (bg2_q > CP2);
  assign new_p[3] = play && fall_q[0] && (bg2_q > CP2);
  assign new_p[4] = win_entry;

  // Adder: one BCD digit per cycle, LSD first; START discards any partial sum.
  always_comb begin
    pend_d   = pend_q | new_p;
    a_busy_d = a_busy_q;
    dig_d    = dig_q;
    carry_d  = carry_q;
    addend_d = addend_q;
    score_d  = score_q;
    sel      = pend_q & (~pend_q + 5'd1);
    dsum     = bcd_digit_add(score_q[{dig_q, 2'b00} +: 4], addend_q[{dig_q, 2'b00} +: 4], carry_q);
    if (state_q == S_START) begin
      pend_d   = '0;
      a_busy_d = 1'b0;
      dig_d    = 2'd0;
      carry_d  = 1'b0;
      score_d  = '0;
    end else if (a_busy_q) begin
      score_d[{dig_q, 2'b00} +: 4] = dsum[3:0];
      carry_d = dsum[4];
      dig_d   = dig_q + 2'd1;
      if (dig_q == 2'd3) begin
        a_busy_d = 1'b0;
        carry_d  = 1'b0;
        score_d  = bcd_saturate(score_d, dsum[4]);
      end
    end else if (|pend_q) begin
      pend_d   = (pend_q & ~sel) | new_p;
      addend_d = award_value(sel);
      a_busy_d = 1'b1;
      dig_d    = 2'd0;
      carry_d  = 1'b0;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      in_q     <= IN_RST;
      prev_q   <= IN_RST;
      rise_q   <= '0;
      fall_q   <= '0;
      bg1_q    <= '0;
      bg2_q    <= '0;
      state_q  <= S_IDLE;
      lives_q  <= 2'd0;
      pend_q   <= '0;
      a_busy_q <= 1'b0;
      dig_q    <= 2'd0;
      carry_q  <= 1'b0;
      addend_q <= '0;
      score_q  <= '0;
    end else begin
      in_q     <= {start_btn, alive, enemy1_alive, save_suc, lastp_alive, p2_alive};
      prev_q   <= in_q;
      rise_q   <= in_q & ~prev_q;
      fall_q   <= ~in_q & prev_q;
      bg1_q    <= bg_position;
      bg2_q    <= bg1_q;
      state_q  <= state_d;
      lives_q  <= lives_d;
      pend_q   <= pend_d;
      a_busy_q <= a_busy_d;
      dig_q    <= dig_d;
      carry_q  <= carry_d;
      addend_q <= addend_d;
      score_q  <= score_d;
    end
  end

`ifdef SCORE_HISCORE_EN
  logic        hs_arm_q;
  logic [15:0] hi_q;
  // Armed on entering OVER/WIN so the compare waits for the final awards.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      hs_arm_q <= 1'b0;
      hi_q     <= '0;
    end else if (state_q == S_START) begin
      hs_arm_q <= 1'b0;
    end else if ((state_d == S_OVER || state_d == S_WIN) && state_d != state_q) begin
      hs_arm_q <= 1'b1;
    end else if (hs_arm_q && !busy) begin
      hs_arm_q <= 1'b0;
      if (score_q > hi_q) hi_q <= score_q;
    end
  end
  assign hi_score = hi_q;
`endif

  assign game_start = (state_q == S_START);
  assign state      = state_q;
  assign lives      = lives_q;
  assign score      = score_q;
  assign busy       = a_busy_q | (|pend_q);

endmodule

// File: tb/tb_score_ctrl.sv
// Randomised scoreboard bench for score_ctrl against a decimal game model.
module tb_score_ctrl;
  logic        Clk = 1'b0;
  logic        Reset;
  logic        start_btn, alive, enemy1_alive, save_suc, lastp_alive, p2_alive;
  logic [15:0] bg_position;
  logic        game_start, busy;
  logic [2:0]  state;
  logic [1:0]  lives;
  logic [15:0] score;
`ifdef SCORE_HISCORE_EN
  logic [15:0] hi_score;
`endif

  score_ctrl dut (
    .Clk(Clk), .Reset(Reset), .start_btn(start_btn), .alive(alive),
    .enemy1_alive(enemy1_alive), .save_suc(save_suc), .lastp_alive(lastp_alive),
    .p2_alive(p2_alive), .bg_position(bg_position), .game_start(game_start),
    .state(state), .lives(lives), .score(score),
`ifdef SCORE_HISCORE_EN
    .hi_score(hi_score),
`endif
    .busy(busy)
  );

  always #5 Clk = ~Clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [15:0] exp_q[$];

  // Reference game model, in decimal points and phase numbers.
  int m_phase = 0;
  int m_lives = 0;
  int m_score = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  function automatic int sat_add(input int s, input int p);
    return (s + p > 9999) ? 9999 : s + p;
  endfunction

  // Monitor: every busy fall presents a final score to the scoreboard.
  logic busy_d1 = 1'b0;
  always @(negedge Clk) begin
    if (busy_d1 && !busy) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_unexpected: score %0h with no expectation queued", score);
      end else begin
        chk("sb_score", score, exp_q.pop_front());
      end
    end
    busy_d1 <= busy;
  end

  task automatic apply(input logic st, input logic al, input logic e1, input logic sv,
                       input logic lp, input logic p2, input int bg, output int fcyc);
    int   naw = 0;
    int   ng  = 0;
    int   gs  = 0;
    logic pb;
    if (m_phase == 2) begin
      if (enemy1_alive && !e1 && bg > 648)  begin m_score = sat_add(m_score, 20); naw++; end
      if (!save_suc && sv && bg > 648)      begin m_score = sat_add(m_score, 30); naw++; end
      if (lastp_alive && !lp && bg > 1298)  begin m_score = sat_add(m_score, 50); naw++; end
      if (p2_alive && !p2 && bg > 1298)     begin m_score = sat_add(m_score, 50); naw++; end
      if (alive && !al) begin
        m_lives--;
        m_phase = (m_lives == 0) ? 4 : 3;
      end
    end else if (m_phase == 3) begin
      if (!alive && al) m_phase = 2;
    end else if (!start_btn && st) begin
      m_phase = 2; m_lives = 3; m_score = 0; ng = 1;
    end
    if (m_phase == 2 && bg > 1298 && !lp && !p2) begin
      m_phase = 5;
      m_score = sat_add(m_score, 100);
      naw++;
    end
    if (naw > 0) exp_q.push_back(to_bcd(m_score));
    start_btn = st; alive = al; enemy1_alive = e1; save_suc = sv;
    lastp_alive = lp; p2_alive = p2; bg_position = 16'(bg);
    fcyc = 0;
    pb = busy;
    for (int k = 1; k <= 8 + 5 * naw + 6; k++) begin
      @(posedge Clk); #1;
      if (game_start) begin
        gs++;
        chk("start_state", state, 3'd1);
      end
      if (pb && !busy && fcyc == 0) fcyc = k;
      pb = busy;
    end
    chk("game_start_cnt", gs, ng);
    chk("state", state, m_phase);
    chk("lives", lives, m_lives);
    chk("score", score, to_bcd(m_score));
    chk("busy_idle", busy, 1'b0);
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int fc;
    Reset = 1'b0;
    start_btn = 0; alive = 1; enemy1_alive = 1; save_suc = 0;
    lastp_alive = 1; p2_alive = 1; bg_position = 0;
    repeat (3) @(posedge Clk);
    #1 Reset = 1'b1;
    chk("rst_state", state, 3'd0);
    chk("rst_lives", lives, 2'd0);
    chk("rst_score", score, 16'h0);
    chk("rst_game_start", game_start, 1'b0);
    chk("rst_busy", busy, 1'b0);
    @(posedge Clk); #1;

    apply(1, 1, 1, 0, 1, 1, 0, fc);
    apply(0, 1, 1, 0, 1, 1, 0, fc);
    apply(0, 1, 0, 0, 1, 1, 700, fc);
    chk("award_latency", fc, 8);
    chk("award_20", score, 16'h0020);
    apply(0, 1, 1, 0, 1, 1, 700, fc);
    apply(0, 1, 0, 0, 1, 1, 600, fc);
    chk("below_cp1", score, 16'h0020);
    apply(0, 1, 1, 0, 1, 1, 0, fc);

    for (int i = 0; i < 3; i++) begin
      apply(0, 0, 1, 0, 1, 1, 0, fc);
      if (i < 2) apply(0, 1, 1, 0, 1, 1, 0, fc);
    end
    chk("over_state", state, 3'd4);
    chk("over_lives", lives, 2'd0);
    apply(1, 0, 1, 0, 1, 1, 0, fc);
    apply(0, 1, 1, 0, 1, 1, 0, fc);

    apply(0, 1, 1, 0, 0, 0, 1300, fc);
    chk("win_latency", fc, 18);
    chk("win_score", score, 16'h0200);
    chk("win_state", state, 3'd5);
    apply(1, 1, 1, 0, 0, 0, 0, fc);
    apply(0, 1, 1, 0, 1, 1, 0, fc);

    // Abort an in-flight add with a new game.
    exp_q.push_back(16'h0000);
    lastp_alive = 0; p2_alive = 0; bg_position = 1300;
    for (int k = 0; k < 20 && !busy; k++) begin @(posedge Clk); #1; end
    chk("abort_busy_rise", busy, 1'b1);
    repeat (6) @(posedge Clk);
    #1;
    chk("abort_in_win", state, 3'd5);
    start_btn = 1; bg_position = 0;
    m_phase = 2; m_lives = 3; m_score = 0;
    repeat (12) @(posedge Clk);
    #1;
    chk("abort_state", state, 3'd2);
    chk("abort_score", score, 16'h0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_lives", lives, 2'd3);
    apply(0, 1, 1, 0, 0, 0, 0, fc);
    apply(0, 1, 1, 0, 1, 1, 1300, fc);

    // Preload 9980 then push past the top.
    for (int i = 0; i < 99; i++) begin
      apply(0, 1, 0, 1, 0, 1, 1300, fc);
      apply(0, 1, 1, 0, 1, 1, 1300, fc);
    end
    apply(0, 1, 1, 1, 0, 1, 1300, fc);
    chk("preload", score, 16'h9980);
    apply(0, 1, 1, 0, 1, 1, 1300, fc);
    apply(0, 1, 1, 0, 1, 0, 1300, fc);
    chk("saturate", score, 16'h9999);

    for (int i = 0; i < 200; i++) begin
      logic [5:0] lv;
      int         bg;
      lv = {start_btn, alive, enemy1_alive, save_suc, lastp_alive, p2_alive};
      for (int b = 0; b < 6; b++)
        if ($urandom_range(0, 99) < 30) lv[b] = ~lv[b];
      bg = int'(bg_position);
      if ($urandom_range(0, 99) < 30) begin
        case ($urandom_range(0, 4))
          0: bg = 600;
          1: bg = 700;
          2: bg = 1000;
          3: bg = 1300;
          default: bg = 2000;
        endcase
      end
      apply(lv[5], lv[4], lv[3], lv[2], lv[1], lv[0], bg, fc);
    end

    repeat (4) @(posedge Clk);
    chk("sb_drain", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/score_ctrl.md
# score_ctrl

Game-phase sequencer and score accumulator for the game top level. Runs the IDLE/PLAY/RESPAWN/OVER/WIN state machine, issues the one-cycle `game_start` clear, and tracks lives. It edge-detects kill, rescue and death events from the sprite logic and adds their point values into a 4-digit BCD score with a digit-serial adder. The score drives the hex display and the on-screen score sprite.

## Interface
- `CP1`, 16'd648: background position past which level-1 events score.
- `CP2`, 16'd1298: background position past which level-2 events score.
- `LIVES`, 2'd3: lives loaded at game start (1–3).
- `Clk`  in  1  system clock.
- `Reset`  in  1  asynchronous, active-low reset.
- `start_btn`  in  1  start key, already synchronised; rising edge is used.
- `alive`  in  1  player alive.
- `enemy1_alive`  in  1  level-1 enemy alive.
- `save_suc`  in  1  hostage rescued (level).
- `lastp_alive`  in  1  boss alive.
- `p2_alive`  in  1  level-2 enemy alive.
- `bg_position`  in  16  background scroll position, unsigned.
- `game_start`  out  1  one-cycle pulse on entering a new game.
- `state`  out  3  IDLE=0, START=1, PLAY=2, RESPAWN=3, OVER=4, WIN=5.
- `lives`  out  2  remaining lives.
- `score`  out  16  BCD score, 4 digits, saturates at 16'h9999.
- `busy`  out  1  adder active or award pending.

## Operation
- All inputs are registered once. An edge is the difference between the current and previous registered value.
- State transitions:
  - IDLE → START on `start_btn` rise.
  - START lasts 1 cycle. It asserts `game_start`, clears `score` and all pending flags, loads `lives=LIVES`, then → PLAY.
  - PLAY → RESPAWN on `alive` fall, with `lives` decremented. If `lives` was 1, the target is OVER instead.
  - PLAY → WIN when `bg_position>CP2`, `lastp_alive==0` and `p2_alive==0`, all in the same cycle.
  - RESPAWN → PLAY on `alive` rise.
  - OVER or WIN → START on `start_btn` rise.
- Award sources are edge-triggered and counted in PLAY only. Each sets a sticky pending flag:
  - P0: `enemy1_alive` fall with `bg_position>CP1`: +0x0020.
  - P1: `save_suc` rise with `bg_position>CP1`: +0x0030.
  - P2: `lastp_alive` fall with `bg_position>CP2`: +0x0050.
  - P3: `p2_alive` fall with `bg_position>CP2`: +0x0050.
  - P4: entry into WIN: +0x0100.
- An event whose flag is already pending is absorbed and not double-counted.
- Adder FSM: A_IDLE → ADD (4 cycles) → A_IDLE.
  - In A_IDLE, the adder takes the lowest-numbered pending flag and clears it.
  - ADD processes one BCD digit per cycle, LSD first: digit sum, decimal adjust (+6 if >9), carry to next digit.
  - After digit 3, if a carry remains, `score` is forced to 16'h9999.
  - Pending flags remain serviceable in RESPAWN, OVER and WIN, so the last awards still land.
- START overrides everything: it aborts an in-flight add and discards the partial sum.

## Timing
- Reset values:
  - `state`=IDLE, `lives`=0, `score`=0, `game_start`=0, `busy`=0, pending=0, adder A_IDLE.
  - Edge registers reset to 1 for `*_alive` inputs and 0 for the others, so no spurious edge appears after reset.
- Input change to edge detection: 2 cycles (sync register plus previous register).
- Edge to pending flag: +1 cycle. Pending flag to adder start: +1 cycle.
- Adder start to `score` update: 4 cycles. `score` updates digit-by-digit in place; the final value is valid when `busy` falls.
- Per award: 8 cycles from input change to final `score`. Simultaneous events serialise at 5 cycles each.
- `game_start` is high for exactly the cycle `state`==START.
- A Reset assertion mid-add clears everything immediately (asynchronous).

## Configuration
- `SCORE_HISCORE_EN` defined:
  - Adds output `hi_score[15:0]` (BCD), reset 0.
  - On entry to OVER or WIN, after `busy` falls, `hi_score` loads `score` if `score > hi_score`, compared as unsigned BCD.
  - START does not clear `hi_score`.
- Undefined: the port and register are absent; all other behaviour is identical.

## Test plan
- Reset, then `start_btn` pulse → `game_start` high 1 cycle, `state`=PLAY, `lives`=3, `score`=0.
- PLAY, `bg_position`=700, `enemy1_alive` 1→0 → `score`=0x0020 8 cycles later. The same drop at `bg_position`=600 → no change.
- `lastp_alive` and `p2_alive` fall in the same cycle with `bg_position`=1300 → awards 50, 50 and WIN +100 serialised, final `score`=0x0200, `state`=WIN.
- Preload `score`=0x9980 via prior awards, then one +0x0050 → `score`=0x9999.
- Three `alive` falls with rises between → `lives` 3→2→1, then OVER on the third fall, `lives`=0; a `start_btn` rise → START.
- Assert `start_btn` rise during an ADD → partial sum discarded, `score`=0, pending cleared, `busy`=0.
